imem_responder: RTL and testbench

- Responder end of the instruction-fetch interface. It accepts the word address driven by the fetch stage on iaddr and returns the instruction on idata, using iready_n as an active-low ready.
- Behind it sits a 16-bit-wide instruction memory with a variable-latency, one-outstanding read handshake. Each word is assembled from two halfword reads.
- A one-entry word buffer returns a repeated address in zero cycles, which covers fetch stalls (keep) and nop holds.

---
 rtl/imem_responder.sv | 153 +++++++++++++++
 tb/tb_imem_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imem_responder
// Brief    : Instruction-fetch responder assembling 32-bit words from two
//            16-bit memory reads, with a one-entry word buffer for repeats.
// Revision : 1.0 - initial release
// ============================================================================
module imem_responder #(
  parameter logic [31:0] BASE        = 32'h0001_0000,
  parameter int          DEPTH_WORDS = 16384,
  parameter int          MEM_AW      = 15,
  parameter int          TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       iaddr,
  output logic [31:0]       idata,
  output logic              iready_n,
  output logic              ierr,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid
);

  localparam int          TW        = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [29:0] BASE_WORD = BASE[31:2];
  localparam logic [29:0] DEPTH_W   = 30'(DEPTH_WORDS);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_LO = 2'd1,
    S_WAIT_HI = 2'd2
  } state_t;

  state_t            state_q;
  logic [29:0]       req_word_q;
  logic [29:0]       buf_word_q;
  logic [31:0]       buf_data_q;
  logic              buf_valid_q;
  logic              buf_err_q;
  logic              abort_q;
  logic [15:0]       lo_q;
  logic [TW-1:0]     timer_q;
  logic              mem_re_q;
  logic [MEM_AW-1:0] mem_addr_q;

  logic [29:0] w_word;
  logic [29:0] w_off;
  logic [30:0] w_hw;
  logic        w_in_range;
  logic        w_hit;
  logic        w_redirect;
  logic        w_abort;
  logic        w_timeout;
  logic        w_unused_bits;

  assign w_word        = iaddr[31:2];
  assign w_off         = w_word - BASE_WORD;
  assign w_hw          = {w_off, 1'b0};
  assign w_in_range    = (iaddr >= BASE) && (w_off < DEPTH_W);
  assign w_hit         = buf_valid_q && (w_word == buf_word_q);
  assign w_redirect    = (w_word != req_word_q);
  // A redirect seen in the same cycle as mem_rvalid also discards the data.
  assign w_abort       = abort_q | w_redirect;
  assign w_timeout     = (timer_q == TIMEOUT_C);
  assign w_unused_bits = ^{iaddr[1:0], w_hw[30:MEM_AW]};

  assign mem_re   = mem_re_q;
  assign mem_addr = mem_addr_q;

  always_comb begin
    iready_n = 1'b1;
    idata    = 32'h0;
    ierr     = 1'b0;
    if (!rst && (state_q == S_IDLE)) begin
      if (w_hit) begin
        iready_n = 1'b0;
        idata    = buf_data_q;
        ierr     = buf_err_q;
      end else if (!w_in_range) begin
        iready_n = 1'b0;
        ierr     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_word_q  <= 30'h0;
      buf_word_q  <= 30'h0;
      buf_data_q  <= 32'h0;
      buf_valid_q <= 1'b0;
      buf_err_q   <= 1'b0;
      abort_q     <= 1'b0;
      lo_q        <= 16'h0;
      timer_q     <= '0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      mem_re_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!w_hit && w_in_range) begin
            req_word_q <= w_word;
            mem_re_q   <= 1'b1;
            mem_addr_q <= w_hw[MEM_AW-1:0];
            timer_q    <= '0;
            abort_q    <= 1'b0;
            state_q    <= S_WAIT_LO;
          end
        end
        S_WAIT_LO, S_WAIT_HI: begin
          if (w_redirect) abort_q <= 1'b1;
          if (mem_rvalid) begin
            if (w_abort) begin
              state_q <= S_IDLE;
            end else if (state_q == S_WAIT_LO) begin
              lo_q       <= mem_rdata;
              mem_re_q   <= 1'b1;
              // The low request left bit 0 clear, so setting it gives the high halfword.
              mem_addr_q <= {mem_addr_q[MEM_AW-1:1], 1'b1};
              timer_q    <= '0;
              state_q    <= S_WAIT_HI;
            end else begin
              buf_data_q  <= {mem_rdata, lo_q};
              buf_word_q  <= req_word_q;
              buf_valid_q <= 1'b1;
              buf_err_q   <= 1'b0;
              state_q     <= S_IDLE;
            end
          end else if (w_timeout) begin
            if (!w_abort) begin
              buf_valid_q <= 1'b1;
              buf_err_q   <= 1'b1;
              buf_data_q  <= 32'h0;
              buf_word_q  <= req_word_q;
            end
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_imem_responder
// Brief    : Self-checking bench for imem_responder with a latency-configurable
//            halfword memory model and an expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_responder;

  localparam logic [31:0] BASE        = 32'h0001_0000;
  localparam int          DEPTH_WORDS = 16384;
  localparam int          MEM_AW      = 15;
  localparam int          TIMEOUT     = 255;

  logic              clk        = 1'b0;
  logic              rst        = 1'b1;
  logic [31:0]       iaddr      = 32'h0;
  logic [31:0]       idata;
  logic              iready_n;
  logic              ierr;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_re;
  logic [15:0]       mem_rdata  = 16'h0;
  logic              mem_rvalid = 1'b0;

  imem_responder #(
    .BASE(BASE), .DEPTH_WORDS(DEPTH_WORDS), .MEM_AW(MEM_AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .iaddr(iaddr), .idata(idata), .iready_n(iready_n),
    .ierr(ierr), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model state (written only by the model process, except the knobs).
  int                lat      = 1;
  bit                mem_drop = 1'b0;
  int                inj_req  = 0;
  int                inj_done = 0;
  int                re_cnt   = 0;
  logic [MEM_AW-1:0] re_log [0:1023];
  bit                pend     = 1'b0;
  int                cnt      = 0;
  logic [MEM_AW-1:0] paddr    = '0;
  logic              re_s;
  logic [MEM_AW-1:0] a_s;

  function automatic logic [15:0] hw_val(input logic [MEM_AW-1:0] a);
    if (a == 0) return 16'h0013;
    if (a == 1) return 16'h0000;
    return 16'hC3A5 ^ {1'b0, a};
  endfunction

  function automatic logic [31:0] word_at(input logic [MEM_AW-1:0] lo);
    return {hw_val(lo + 15'd1), hw_val(lo)};
  endfunction

  always @(posedge clk) begin
    re_s = mem_re;
    a_s  = mem_addr;
    #1;
    mem_rvalid = 1'b0;
    if (re_s === 1'b1) begin
      re_log[re_cnt % 1024] = a_s;
      re_cnt++;
      if (!mem_drop) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = a_s;
      end
    end
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = hw_val(paddr);
        pend       = 1'b0;
      end
    end
    if (inj_req != inj_done) begin
      inj_done   = inj_req;
      mem_rvalid = 1'b1;
      mem_rdata  = 16'hDEAD;
    end
  end

  typedef struct {
    logic [31:0]       data;
    logic              err;
    int                cyc;
    int                nreq;
    logic [MEM_AW-1:0] lo;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          l;
    exp_t        e;
  } vec_t;

  exp_t sbq[$];
  vec_t v[11];

  function automatic exp_t mk(input logic [31:0] d, input logic e, input int c,
                              input int n, input logic [MEM_AW-1:0] lo);
    exp_t x;
    x.data = d; x.err = e; x.cyc = c; x.nreq = n; x.lo = lo;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input string name, input logic [31:0] addr, input int l, input exp_t e);
    int   n;
    int   s;
    exp_t x;
    n   = 0;
    lat = l;
    s   = re_cnt;
    iaddr = addr;
    sbq.push_back(e);
    #1;
    while (iready_n !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    x = sbq.pop_front();
    check({name, " cycles"}, n, x.cyc);
    check({name, " idata"}, idata, x.data);
    check({name, " ierr"}, {31'h0, ierr}, {31'h0, x.err});
    if (x.cyc == 0) begin
      tick();
      tick();
      check({name, " held ready"}, {31'h0, iready_n}, 32'h0);
    end
    check({name, " mem reads"}, re_cnt - s, x.nreq);
    if (x.nreq == 2 && (re_cnt - s) == 2) begin
      check({name, " lo addr"}, 32'(re_log[s % 1024]), 32'(x.lo));
      check({name, " hi addr"}, 32'(re_log[(s + 1) % 1024]), 32'(x.lo) + 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  initial begin
    int s;
    int n;

    v[0]  = '{32'h0001_0000, 1, mk(32'h0000_0013, 1'b0, 5, 2, 15'h0000)};
    v[1]  = '{32'h0001_0000, 1, mk(32'h0000_0013, 1'b0, 0, 0, 15'h0000)};
    v[2]  = '{32'h0001_0002, 1, mk(32'h0000_0013, 1'b0, 0, 0, 15'h0000)};
    v[3]  = '{32'h0000_FFFC, 1, mk(32'h0, 1'b1, 0, 0, 15'h0000)};
    v[4]  = '{32'h0002_0000, 1, mk(32'h0, 1'b1, 0, 0, 15'h0000)};
    v[5]  = '{32'h0001_0100, 3, mk(word_at(15'h0080), 1'b0, 9, 2, 15'h0080)};
    v[6]  = '{32'h0001_0104, 2, mk(word_at(15'h0082), 1'b0, 7, 2, 15'h0082)};
    v[7]  = '{32'h0001_0100, 1, mk(word_at(15'h0080), 1'b0, 5, 2, 15'h0080)};
    v[8]  = '{32'h0001_FFFC, 1, mk(word_at(15'h7FFE), 1'b0, 5, 2, 15'h7FFE)};
    v[9]  = '{32'hFFFF_FFFC, 1, mk(32'h0, 1'b1, 0, 0, 15'h0000)};
    v[10] = '{32'h0001_FFFC, 1, mk(word_at(15'h7FFE), 1'b0, 0, 0, 15'h0000)};

    rst   = 1'b1;
    iaddr = BASE;
    tick();
    tick();
    check("reset iready_n", {31'h0, iready_n}, 32'h1);
    check("reset idata", idata, 32'h0);
    check("reset ierr", {31'h0, ierr}, 32'h0);
    check("reset mem_re", {31'h0, mem_re}, 32'h0);
    check("reset mem_addr", 32'(mem_addr), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++)
      fetch($sformatf("vec%0d", i), v[i].addr, v[i].l, v[i].e);

    s = re_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("hold%0d iready_n", i), {31'h0, iready_n}, 32'h0);
      check($sformatf("hold%0d idata", i), idata, word_at(15'h7FFE));
    end
    check("hold mem reads", re_cnt - s, 0);

    // Redirect during WAIT_LO: outstanding low read is discarded.
    lat = 3;
    s   = re_cnt;
    iaddr = 32'h0001_0008;
    #1;
    tick();
    iaddr = 32'h0001_0040;
    n = 1;
    while (iready_n !== 1'b0 && n < 400) begin tick(); n++; end
    check("redir cycles", n, 14);
    check("redir idata", idata, word_at(15'h0020));
    check("redir ierr", {31'h0, ierr}, 32'h0);
    check("redir mem reads", re_cnt - s, 3);
    check("redir addr0", 32'(re_log[s % 1024]), 32'h4);
    check("redir addr1", 32'(re_log[(s + 1) % 1024]), 32'h20);
    check("redir addr2", 32'(re_log[(s + 2) % 1024]), 32'h21);

    // Branch away and straight back: the access is still thrown away and refetched.
    s = re_cnt;
    iaddr = 32'h0001_000C;
    #1;
    tick();
    iaddr = 32'h0001_0010;
    tick();
    iaddr = 32'h0001_000C;
    n = 2;
    while (iready_n !== 1'b0 && n < 400) begin tick(); n++; end
    check("return cycles", n, 14);
    check("return idata", idata, word_at(15'h0006));
    check("return mem reads", re_cnt - s, 3);
    check("return addr0", 32'(re_log[s % 1024]), 32'h6);
    check("return addr1", 32'(re_log[(s + 1) % 1024]), 32'h6);
    check("return addr2", 32'(re_log[(s + 2) % 1024]), 32'h7);

    // Timeout with a silent memory, then a late response in IDLE.
    mem_drop = 1'b1;
    s = re_cnt;
    iaddr = 32'h0001_0200;
    #1;
    n = 0;
    while (iready_n !== 1'b0 && n < 400) begin tick(); n++; end
    check("tmo cycles", n, 257);
    check("tmo idata", idata, 32'h0);
    check("tmo ierr", {31'h0, ierr}, 32'h1);
    check("tmo lo addr", 32'(re_log[s % 1024]), 32'h100);
    mem_drop = 1'b0;
    inj_req++;
    tick();
    tick();
    tick();
    check("late iready_n", {31'h0, iready_n}, 32'h0);
    check("late ierr", {31'h0, ierr}, 32'h1);
    check("late idata", idata, 32'h0);
    check("late mem reads", re_cnt - s, 1);

    // Reset during WAIT_HI.
    lat = 3;
    s = re_cnt;
    iaddr = 32'h0001_0300;
    #1;
    repeat (6) tick();
    check("pre-rst reads", re_cnt - s, 2);
    rst = 1'b1;
    #1;
    check("in-rst iready_n", {31'h0, iready_n}, 32'h1);
    tick();
    check("rst iready_n", {31'h0, iready_n}, 32'h1);
    check("rst mem_re", {31'h0, mem_re}, 32'h0);
    check("rst idata", idata, 32'h0);
    rst   = 1'b0;
    iaddr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stale%0d ierr", i), {31'h0, ierr}, 32'h1);
    end
    check("stale mem reads", re_cnt - s, 2);
    fetch("post-rst fault cleared", 32'h0001_0200, 1, mk(word_at(15'h0100), 1'b0, 5, 2, 15'h0100));
    fetch("post-rst refetch", 32'h0001_0300, 1, mk(word_at(15'h0180), 1'b0, 5, 2, 15'h0180));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
